load_store_unit: RTL and testbench

- Initiator side of the RV32I data-memory interface. Converts core load/store requests, with valid/ready handshakes on request and response, into the memory block's single-cycle write and registered-read protocol.
- Checks alignment, funct3 legality and address-map faults before touching memory.
- Buffers load data under response backpressure.
- Sits between the core execute stage and the memory block.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_check.sv | 49 ++++
 rtl/load_store_unit.sv | 117 +++++++++++
 tb/tb_load_store_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the RV32I load/store unit: FSM states,
// response error codes, funct3 encodings and the peripheral address map.
package lsu_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_FAULT    = 2'd2;
    localparam logic [1:0] ERR_FUNCT3   = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] MMIO_MICROS = 32'hFFFF_FFF4;
    localparam logic [31:0] MMIO_MILLIS = 32'hFFFF_FFF8;
    localparam logic [31:0] MMIO_LEDS   = 32'hFFFF_FFFC;

    // Registered copy of an accepted request, replayed to memory while busy.
    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    // Drops the low address bits a word/half access cannot use.
    function automatic logic [31:0] align_addr(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] a;
        a = addr;
        if (f3 == F3_W)
            a[1:0] = 2'b00;
        else if (f3 == F3_H || f3 == F3_HU)
            a[0] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/lsu_check.sv
// Request legality checker: funct3, alignment (LSU_MISALIGN_CHECK_EN) and address map; first match wins.
// Latency: purely combinational.
// Backpressure: none, stateless.
module lsu_check
    import lsu_pkg::*;
#(
    parameter int unsigned RAM_BYTES = 8192,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF4
) (
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic [1:0]  err
);

    logic bad_f3;
    logic in_map;
    logic read_only;

    always_comb begin
        bad_f3    = write ? (funct3[2] || funct3 == 3'b011)
                          : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        in_map    = (addr < 32'(RAM_BYTES)) || (addr >= MMIO_BASE);
        // micros/millis sit in the first two MMIO words and cannot be stored to
        read_only = (addr >= MMIO_BASE) && (addr < MMIO_BASE + (MMIO_LEDS - MMIO_MICROS));
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic misal;

    always_comb begin
        misal = ((funct3 == F3_W) && (addr[1:0] != 2'b00))
             || ((funct3 == F3_H || funct3 == F3_HU) && addr[0]);
    end
`endif

    always_comb begin
        err = ERR_NONE;
        if (bad_f3)
            err = ERR_FUNCT3;
`ifdef LSU_MISALIGN_CHECK_EN
        else if (misal)
            err = ERR_MISALIGN;
`endif
        else if (!in_map || (write && read_only))
            err = ERR_FAULT;
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory initiator: checks requests, drives single-cycle writes and registered reads.
// Latency: response 1 cycle after accept, at least 2 cycles per transaction.
// Backpressure: resp_ready low parks load data in a hold register; req_ready is low until the response is taken.
// LSU_MISALIGN_CHECK_EN: misaligned word/half reports err=1; otherwise the low address bits are forced to zero.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned RAM_BYTES = 8192,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        write_mem,
    output logic [2:0]  funct3,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic [31:0] read_address,
    input  logic [31:0] read_data
);

    logic [1:0]  state;
    acc_t        acc_q;
    logic [31:0] hold_rdata;
    logic [1:0]  hold_err;
    logic [1:0]  chk_err;
    logic [31:0] addr_eff;
    logic        idle;
    logic        accept;

    lsu_check #(
        .RAM_BYTES (RAM_BYTES),
        .MMIO_BASE (MMIO_BASE)
    ) u_check (
        .write  (req_write),
        .funct3 (req_funct3),
        .addr   (req_addr),
        .err    (chk_err)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    assign addr_eff = req_addr;
`else
    assign addr_eff = align_addr(req_funct3, req_addr);
`endif

    assign idle      = (state == IDLE);
    assign req_ready = idle;
    assign accept    = req_valid && idle;
    // rst_n gates the strobe so an in-flight write is killed the moment reset asserts
    assign write_mem = rst_n && accept && req_write && (chk_err == ERR_NONE);

    assign read_address  = idle ? addr_eff   : acc_q.addr;
    assign write_address = idle ? addr_eff   : acc_q.addr;
    assign funct3        = idle ? req_funct3 : acc_q.f3;
    assign write_data    = idle ? req_wdata  : acc_q.wdata;

    assign resp_valid = !idle;

    always_comb begin
        resp_rdata = 32'd0;
        resp_err   = ERR_NONE;
        if (state == RD_WAIT) begin
            resp_rdata = read_data;
        end else if (state == HOLD) begin
            resp_rdata = hold_rdata;
            resp_err   = hold_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc_q      <= '0;
            hold_rdata <= 32'd0;
            hold_err   <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_q.f3    <= req_funct3;
                        acc_q.addr  <= addr_eff;
                        acc_q.wdata <= req_wdata;
                        hold_rdata  <= 32'd0;
                        hold_err    <= chk_err;
                        state       <= (chk_err != ERR_NONE || req_write) ? HOLD : RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // memory only guarantees read_data for this one cycle
                    if (resp_ready) begin
                        state <= IDLE;
                    end else begin
                        hold_rdata <= read_data;
                        hold_err   <= ERR_NONE;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: memory model with one-cycle read data,
// transaction-level reference model, per-cycle compare plus directed literal checks.
module tb_load_store_unit;

    localparam int          RAM = 8192;
    localparam logic [31:0] MB  = 32'hFFFF_FFF4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address, write_data, read_address, read_data;

    load_store_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .write_mem     (write_mem),
        .funct3        (funct3),
        .write_address (write_address),
        .write_data    (write_data),
        .read_address  (read_address),
        .read_data     (read_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- specification-level helpers ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3 == 3'b010) return 4;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] eff(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        return a;
`else
        return a - (a % 32'(acc_size(f3)));
`endif
    endfunction

    function automatic logic [1:0] ref_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = w ? (f3 inside {3'b000, 3'b001, 3'b010})
                  : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (!legal) return 2'd3;
`ifdef LSU_MISALIGN_CHECK_EN
        if ((a % 32'(acc_size(f3))) != 0) return 2'd1;
`endif
        if (!(a < 32'(RAM) || a >= MB)) return 2'd2;
        if (w && a >= MB && a < MB + 32'd8) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return 8'(a * 37 + (a >> 5));
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // ---------------- memory block model ----------------
    logic [7:0] mem_ram [RAM];
    logic [7:0] mem_io  [12];

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a < 32'(RAM)) return mem_ram[a[12:0]];
        if (a >= MB) return mem_io[4'(a - MB)];
        return 8'h00;
    endfunction

    function automatic logic [31:0] mem_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem_byte(a + 32'(k));
        return extend(f3, w);
    endfunction

    // read data is only meaningful the cycle after an accept; otherwise it is garbage
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM; i++) mem_ram[i] <= init_byte(32'(i));
            for (int i = 0; i < 12; i++) mem_io[i] <= init_byte(MB + 32'(i));
            read_data <= 32'd0;
        end else begin
            if (write_mem) begin
                for (int k = 0; k < acc_size(funct3); k++) begin
                    if (write_address + 32'(k) < 32'(RAM))
                        mem_ram[13'(write_address + 32'(k))] <= write_data[8*k +: 8];
                    else if (write_address + 32'(k) >= MB)
                        mem_io[4'(write_address + 32'(k) - MB)] <= write_data[8*k +: 8];
                end
            end
            read_data <= (req_valid && req_ready) ? mem_load(funct3, read_address) : $urandom;
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [7:0]  ref_ram [RAM];
    logic [7:0]  ref_io  [12];
    logic        busy;
    logic [31:0] m_rdata, m_addr;
    logic [1:0]  m_err;
    logic [2:0]  m_f3;

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        if (a < 32'(RAM)) return ref_ram[a[12:0]];
        if (a >= MB) return ref_io[4'(a - MB)];
        return 8'h00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_byte(a + 32'(k));
        return extend(f3, w);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM; i++) ref_ram[i] <= init_byte(32'(i));
            for (int i = 0; i < 12; i++) ref_io[i] <= init_byte(MB + 32'(i));
            busy    <= 1'b0;
            m_rdata <= 32'd0;
            m_addr  <= 32'd0;
            m_err   <= 2'd0;
            m_f3    <= 3'd0;
        end else if (!busy && req_valid) begin
            busy    <= 1'b1;
            m_err   <= ref_err(req_write, req_funct3, req_addr);
            m_addr  <= eff(req_funct3, req_addr);
            m_f3    <= req_funct3;
            m_rdata <= (ref_err(req_write, req_funct3, req_addr) == 2'd0 && !req_write)
                       ? ref_load(req_funct3, eff(req_funct3, req_addr)) : 32'd0;
            if (ref_err(req_write, req_funct3, req_addr) == 2'd0 && req_write) begin
                for (int k = 0; k < acc_size(req_funct3); k++) begin
                    if (eff(req_funct3, req_addr) + 32'(k) < 32'(RAM))
                        ref_ram[13'(eff(req_funct3, req_addr) + 32'(k))] <= req_wdata[8*k +: 8];
                    else
                        ref_io[4'(eff(req_funct3, req_addr) + 32'(k) - MB)] <= req_wdata[8*k +: 8];
                end
            end
        end else if (busy && resp_ready) begin
            busy <= 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] last_rdata, last_waddr, last_wdata;
    logic [1:0]  last_err;
    int          wr_cnt = 0;

    task automatic txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int stall);
        bit acc, hs;
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        req_valid = 1'b1; resp_ready = 1'($urandom);
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk); acc = req_ready;
            @(posedge clk); #1;
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        for (int s = 0; s < stall; s++) begin
            req_valid = 1'($urandom); req_write = 1'($urandom);
            req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
            resp_ready = 1'b0;
            @(posedge clk); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        hs = 1'b0;
        for (int k = 0; k < 20 && !hs; k++) begin
            @(negedge clk); hs = resp_valid;
            @(posedge clk); #1;
        end
        chk("resp_timeout", 32'(hs), 32'd1);
        resp_ready = 1'b0;
    endtask

    task automatic expect_resp(input string name, input logic [31:0] rdata, input logic [1:0] err);
        chk({name, "_rdata"}, last_rdata, rdata);
        chk({name, "_err"}, 32'(last_err), 32'(err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [2:0] f3;
        logic [31:0] a;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;

        // per-cycle comparison against the reference model
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    chk("req_ready", 32'(req_ready), 32'(!busy));
                    chk("resp_valid", 32'(resp_valid), 32'(busy));
                    chk("write_mem", 32'(write_mem),
                        32'(!busy && req_valid && req_write && ref_err(req_write, req_funct3, req_addr) == 2'd0));
                    if (busy) begin
                        chk("resp_rdata", resp_rdata, m_rdata);
                        chk("resp_err", 32'(resp_err), 32'(m_err));
                        chk("read_address_held", read_address, m_addr);
                        chk("funct3_held", 32'(funct3), 32'(m_f3));
                    end else begin
                        chk("read_address", read_address, eff(req_funct3, req_addr));
                        chk("funct3", 32'(funct3), 32'(req_funct3));
                        if (write_mem) begin
                            chk("write_address", write_address, eff(req_funct3, req_addr));
                            chk("write_data", write_data, req_wdata);
                        end
                    end
                    if (resp_valid && resp_ready) begin
                        last_rdata = resp_rdata;
                        last_err   = resp_err;
                    end
                    if (write_mem) begin
                        wr_cnt++;
                        last_waddr = write_address;
                        last_wdata = write_data;
                    end
                end
            end
        join_none

        #1 rst_n = 1'b0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);
        chk("reset_write_mem", 32'(write_mem), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // model pins
        chk("model_err_ld011", 32'(ref_err(1'b0, 3'b011, 32'h10)), 32'd3);
        chk("model_err_st_ro", 32'(ref_err(1'b1, 3'b010, 32'hFFFF_FFF8)), 32'd2);

        // store then load
        w0 = wr_cnt;
        txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        chk("sw_write_count", 32'(wr_cnt - w0), 32'd1);
        chk("sw_write_address", last_waddr, 32'h10);
        chk("sw_write_data", last_wdata, 32'hDEAD_BEEF);
        expect_resp("sw", 32'd0, 2'd0);
        txn(1'b0, 3'b000, 32'h13, 32'd0, 0);
        expect_resp("lb_13", 32'hFFFF_FFDE, 2'd0);

        // backpressure with junk requests on the bus
        txn(1'b0, 3'b010, 32'h10, 32'd0, 3);
        expect_resp("lw_stall", 32'hDEAD_BEEF, 2'd0);

`ifdef LSU_MISALIGN_CHECK_EN
        w0 = wr_cnt;
        txn(1'b0, 3'b001, 32'h11, 32'd0, 0);
        expect_resp("lh_misal", 32'd0, 2'd1);
        txn(1'b1, 3'b001, 32'h11, 32'h1234, 1);
        expect_resp("sh_misal", 32'd0, 2'd1);
        chk("misal_no_write", 32'(wr_cnt - w0), 32'd0);
`else
        txn(1'b1, 3'b010, 32'h12, 32'h1234_5678, 0);
        chk("sw_12_address", last_waddr, 32'h10);
        expect_resp("sw_12", 32'd0, 2'd0);
        txn(1'b0, 3'b001, 32'h11, 32'd0, 2);
        expect_resp("lh_11", 32'h0000_5678, 2'd0);
`endif

        // address map faults
        w0 = wr_cnt;
        txn(1'b1, 3'b010, 32'hFFFF_FFF8, 32'h1, 0);
        expect_resp("sw_ro", 32'd0, 2'd2);
        txn(1'b0, 3'b010, 32'h2000, 32'd0, 1);
        expect_resp("lw_hole", 32'd0, 2'd2);
        chk("fault_no_write", 32'(wr_cnt - w0), 32'd0);
        txn(1'b1, 3'b000, 32'hFFFF_FFFE, 32'h80, 0);
        chk("sb_led_write", 32'(wr_cnt - w0), 32'd1);
        expect_resp("sb_led", 32'd0, 2'd0);
        txn(1'b0, 3'b000, 32'hFFFF_FFFE, 32'd0, 0);
        expect_resp("lb_led", 32'hFFFF_FF80, 2'd0);

        // illegal funct3
        txn(1'b0, 3'b011, 32'h10, 32'd0, 0);
        expect_resp("ld_f3_011", 32'd0, 2'd3);
        txn(1'b1, 3'b100, 32'h10, 32'hFF, 2);
        expect_resp("st_f3_100", 32'd0, 2'd3);

        // reset kills a pending write strobe immediately
        req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h55; req_valid = 1'b1;
        #1 chk("wm_before_reset", 32'(write_mem), 32'd1);
        rst_n = 1'b0;
        #1 chk("wm_in_reset", 32'(write_mem), 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // reset while a response is held
        req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h66; req_valid = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold_before_reset", 32'(resp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("hold_reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("hold_reset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        txn(1'b1, 3'b010, 32'h24, 32'hCAFE_F00D, 0);
        txn(1'b0, 3'b101, 32'h26, 32'd0, 1);
        expect_resp("after_reset_lhu", 32'h0000_CAFE, 2'd0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 63));
                1:       a = 32'(RAM - 8) + 32'($urandom_range(0, 15));
                2:       a = MB + 32'($urandom_range(0, 11));
                default: a = $urandom;
            endcase
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            txn(1'($urandom), f3, a, $urandom, $urandom_range(0, 3));
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
